// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access size encoding and FSM states.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    RESP = 2'b10
  } state_e;

  // True when the size/offset pair cannot be served as a naturally aligned access.
  function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_extract.sv
// Selects the addressed byte/half lane of a little-endian word and extends it to 32 bits.
module dmem_lane_extract
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by zero/sign extension according to the access size.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    result   = '0;
    case (size)
      SZ_BYTE: result = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: result = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      SZ_WORD: result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: byte/half/word loads and stores with
// fault detection, valid/ready handshakes on both request and response sides.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_e state, state_nxt;

  size_e         size_in;
  logic [AW-1:0] idx_in;
  logic          accept;
  logic          fault;
  logic          wr_en;
  logic [3:0]    be;
  logic [3:0]    we_lanes;
  logic [31:0]   wdata_lanes;

  logic [3:0][7:0] mem [DEPTH];

  // Fields captured at accept (data) and the response qualifiers (control).
  logic [AW-1:0] idx_p0;
  logic [1:0]    lane_p0;
  size_e         size_p0;
  logic          uns_p0;
  logic          err_p0;
  logic          load_p0;

  // Addressed word fetched during READ.
  logic [31:0] word_p1;
  logic [31:0] ext_data;

  assign size_in  = size_e'(req_size);
  assign idx_in   = req_addr[AW+1:2];
  assign accept   = req_valid & req_ready;
  assign wr_en    = accept & req_we & ~fault & reset;
  assign we_lanes = be & {4{wr_en}};

  // Fault: illegal size, misalignment, or any address bit above the storage range.
  always_comb begin
    fault = misaligned(size_in, req_addr[1:0]);
    if (req_addr[31:AW+2] != '0) fault = 1'b1;
  end

  // Byte-lane enables and lane-replicated store data for the current request.
  always_comb begin
    be          = 4'b0000;
    wdata_lanes = req_wdata;
    case (size_in)
      SZ_BYTE: begin
        be          = 4'b0001 << req_addr[1:0];
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be          = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Storage: per-lane write on the accept edge, never reset.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (we_lanes[l]) mem[idx_in][l] <= wdata_lanes[l*8 +: 8];
    end
  end

  // ---- stage p0: request fields sampled at accept ----
  // Data-path capture of the accepted request; held until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p0  <= idx_in;
      lane_p0 <= req_addr[1:0];
      size_p0 <= size_in;
      uns_p0  <= req_unsigned;
    end
  end

  // Response qualifiers for the accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_p0  <= 1'b0;
      load_p0 <= 1'b0;
    end else if (accept) begin
      err_p0  <= fault;
      load_p0 <= ~req_we;
    end
  end

  // ---- stage p1: addressed word read in READ ----
  // Synchronous read of the latched word index.
  always_ff @(posedge clk) begin
    if (state == READ) word_p1 <= mem[idx_p0];
  end

  dmem_lane_extract u_extract (
    .word        (word_p1),
    .addr_lo     (lane_p0),
    .size        (size_p0),
    .is_unsigned (uns_p0),
    .result      (ext_data)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: stores and faults respond directly, legal loads pass through READ.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (fault || req_we) ? RESP : READ;
      READ: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: response is only driven in RESP, and rdata only for good loads.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_err   = rsp_valid & err_p0;
    rsp_rdata = (rsp_valid && load_p0 && !err_p0) ? ext_data : 32'h0;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, storage depth in 32-bit words (power of two, 16..4096).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  initiator presents a memory access.
REQ-005 req_ready  output  1  responder accepts the access this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  load zero-extends (lbu/lhu) when 1, sign-extends when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator consumes the response.
REQ-013 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_err  output  1  access faulted (misaligned, illegal size, out of range).

Function
REQ-015 FSM states IDLE, READ, RESP; req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready.
REQ-016 IDLE + accepted legal store: SHALL write enabled lanes on the accept edge, go to RESP; rsp_valid 1 cycle after accept.
REQ-017 IDLE + accepted legal load: SHALL go to READ latching the addressed word, then RESP with extracted data; rsp_valid 2 cycles after accept.
REQ-018 IDLE + accepted faulting access: SHALL go straight to RESP with rsp_err=1, rsp_rdata=0, no memory write.
REQ-019 RESP: rsp_valid, rsp_rdata, rsp_err SHALL hold stable until rsp_ready=1; on that edge go to IDLE (no new accept in that same cycle).
REQ-020 Word index = req_addr[log2(DEPTH)+1:2]; little-endian, byte lane = req_addr[1:0], half lane = req_addr[1].
REQ-021 Store byte writes only lane addr[1:0] from req_wdata[7:0]; halfword writes lanes {addr[1],0},{addr[1],1} from req_wdata[15:0]; word writes all lanes.
REQ-022 Load byte/half SHALL select the lane and extend per req_unsigned; word returns the full word (req_unsigned ignored).
REQ-023 Fault conditions: req_size=11; half with addr[0]=1; word with addr[1:0]!=0; req_addr >= 4*DEPTH (no wrap-around aliasing).
REQ-024 req_valid while not IDLE SHALL be ignored (not accepted, not lost internally); request fields sampled only at accept.
REQ-025 Store then load to the same address in consecutive transactions SHALL return the new data.

Reset
REQ-026 reset low SHALL force IDLE immediately: req_ready=1 after deassertion, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-027 Reset mid-transaction SHALL drop the pending response; a store already accepted remains written; storage array is not cleared.

Structure
REQ-028 Shared package dmem_pkg SHALL hold the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL) and FSM state enum.
REQ-029 Lane extraction/extension SHALL be a combinational sub-module dmem_lane_extract (word, addr[1:0], size, unsigned -> 32-bit result).
REQ-030 Storage SHALL be a per-byte-lane write-enabled array, no reset.

Verification
REQ-031 Store word 0xDEADBEEF @0x10, load word @0x10 -> rsp_valid 2 cycles after accept, rdata 0xDEADBEEF, err 0.
REQ-032 Store byte 0x80 @0x13, load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0x80ADBEEF.
REQ-033 Store half 0x8001 @0x22, load half signed @0x22 -> 0xFFFF8001, unsigned -> 0x00008001; half load @0x21 -> err=1, rdata 0.
REQ-034 Word store @0x402 with DEPTH=256 and word load @0x400 -> err=1, rsp_valid 1 cycle after accept, memory unchanged.
REQ-035 Hold rsp_ready=0 five cycles in RESP with req_valid=1 -> outputs stable, req_ready=0, no second accept; rsp_ready=1 -> IDLE next cycle.
REQ-036 Assert reset in READ -> rsp_valid stays 0, req_ready=1 after release; prior store data still readable.
